uart_rx_stream: RTL and testbench

UART_RX_STREAM -- requirements
Module: uart_rx_stream

---
 rtl/uart_rx_stream.sv | 237 +++++++++++++++++++++++
 tb/tb_uart_rx_stream.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_stream.sv
// uart_rx_stream
//   8N1 UART receiver feeding a small receive FIFO. The FIFO's head byte is
//   presented as an AXI-Stream master.
//
//   Ports
//     axis_clk    : sole clock; all state changes on its rising edge
//     axis_rst_n  : asynchronous active-low reset
//     uart_rx     : serial input (idle high, LSB first); asynchronous to axis_clk
//     sm_tvalid   : FIFO non-empty
//     sm_tdata    : oldest byte in the FIFO
//     sm_tready   : consumer ready; pop on sm_tvalid && sm_tready
//     rx_count    : bytes currently held in the FIFO (0..FIFO_DEPTH)
//     irq         : level interrupt = sm_tvalid | frame_err | overrun
//     frame_err   : sticky; a stop bit was sampled low
//     overrun     : sticky; a received byte was dropped because the FIFO was full
//     err_clr     : one-cycle pulse clearing both sticky flags (a new error wins)
module uart_rx_stream #(
  parameter int CLKS_PER_BIT = 4167,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                          axis_clk,
  input  logic                          axis_rst_n,
  input  logic                          uart_rx,
  output logic                          sm_tvalid,
  output logic [7:0]                    sm_tdata,
  input  logic                          sm_tready,
  output logic [$clog2(FIFO_DEPTH):0]   rx_count,
  output logic                          irq,
  output logic                          frame_err,
  output logic                          overrun,
  input  logic                          err_clr
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = 16;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_MID  = CW'(CLKS_PER_BIT / 2);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);

  // ---------------------------------------------------------------------------
  // Input synchronizer; both stages reset to the idle (high) line level.
  // ---------------------------------------------------------------------------
  logic sync1_reg;
  logic rx_s_reg;

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      sync1_reg <= 1'b1;
      rx_s_reg  <= 1'b1;
    end else begin
      sync1_reg <= uart_rx;
      rx_s_reg  <= sync1_reg;
    end
  end

  // ---------------------------------------------------------------------------
  // Receive FSM
  // ---------------------------------------------------------------------------
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } state_t;

  state_t        state_reg;
  logic [CW-1:0] cnt_reg;
  logic [2:0]    bit_idx_reg;
  logic [7:0]    shift_reg;
  logic          frame_err_reg;

  logic cnt_last;
  logic push_req;
  logic stop_bad;

  assign cnt_last = (cnt_reg == CNT_LAST);
  // Stop-bit sample: the byte is offered to the FIFO in this very cycle so it
  // is visible on the stream one cycle later.
  assign push_req = (state_reg == STOP) && cnt_last && rx_s_reg;
  assign stop_bad = (state_reg == STOP) && cnt_last && !rx_s_reg;

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      bit_idx_reg   <= '0;
      shift_reg     <= '0;
      frame_err_reg <= 1'b0;
    end else begin
      // A fresh framing error takes priority over a simultaneous clear.
      if (stop_bad) begin
        frame_err_reg <= 1'b1;
      end else if (err_clr) begin
        frame_err_reg <= 1'b0;
      end

      case (state_reg)
        IDLE: begin
          cnt_reg <= '0;
          if (!rx_s_reg) begin
            state_reg <= START;
          end
        end

        START: begin
          if (cnt_reg == CNT_MID) begin
            cnt_reg     <= '0;
            bit_idx_reg <= '0;
            // Line back high at mid start bit: a glitch, not a frame.
            state_reg   <= rx_s_reg ? IDLE : DATA;
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end

        DATA: begin
          if (cnt_last) begin
            cnt_reg                <= '0;
            shift_reg[bit_idx_reg] <= rx_s_reg;
            bit_idx_reg            <= bit_idx_reg + 3'd1;
            if (bit_idx_reg == 3'd7) begin
              state_reg <= STOP;
            end
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end

        STOP: begin
          if (cnt_last) begin
            cnt_reg   <= '0;
            state_reg <= rx_s_reg ? IDLE : WAIT_IDLE;
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end

        WAIT_IDLE: begin
          // Hold off during a break until the line returns high.
          cnt_reg <= '0;
          if (rx_s_reg) begin
            state_reg <= IDLE;
          end
        end

        default: begin
          state_reg <= IDLE;
          cnt_reg   <= '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Receive FIFO. sm_tdata is a register that always holds the head entry;
  // it is reloaded only when the head changes, so it stays stable under
  // back-pressure and holds its last value after the final pop.
  // ---------------------------------------------------------------------------
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW-1:0] rd_ptr_next;
  logic [AW:0]   count_reg;
  logic [7:0]    tdata_reg;
  logic          overrun_reg;

  logic full;
  logic do_pop;
  logic do_push;
  logic drop;
  logic load_head;
  logic [7:0] head_next;

  assign full    = (count_reg == CNT_FULL);
  assign do_pop  = (count_reg != '0) && sm_tready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign do_push = push_req && (!full || do_pop);
  assign drop    = push_req && full && !do_pop;

  assign rd_ptr_next = do_pop ? (rd_ptr_reg + 1'b1) : rd_ptr_reg;

  // Head changes when a byte lands in an empty FIFO, or a pop leaves
  // something behind (either an older entry or the byte written this cycle).
  assign load_head = (do_push && (count_reg == '0)) ||
                     (do_pop && ((count_reg > CNT_ONE) || do_push));

  // Bypass when the new head is the byte being written this cycle.
  assign head_next = (do_push && (wr_ptr_reg == rd_ptr_next)) ? shift_reg
                                                              : mem[rd_ptr_next];

  always_ff @(posedge axis_clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= shift_reg;
    end
  end

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      count_reg   <= '0;
      tdata_reg   <= '0;
      overrun_reg <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      rd_ptr_reg <= rd_ptr_next;

      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CNT_ONE;
        2'b01:   count_reg <= count_reg - CNT_ONE;
        default: count_reg <= count_reg;
      endcase

      if (load_head) begin
        tdata_reg <= head_next;
      end

      if (drop) begin
        overrun_reg <= 1'b1;
      end else if (err_clr) begin
        overrun_reg <= 1'b0;
      end
    end
  end

  assign sm_tvalid = (count_reg != '0);
  assign sm_tdata  = tdata_reg;
  assign rx_count  = count_reg;
  assign frame_err = frame_err_reg;
  assign overrun   = overrun_reg;
  assign irq       = sm_tvalid | frame_err_reg | overrun_reg;

endmodule

// File: tb/tb_uart_rx_stream.sv
// Bench for uart_rx_stream with CLKS_PER_BIT=16, FIFO_DEPTH=4.
// Bytes expected on the stream are queued when their frames are driven and
// popped by a monitor at every handshake.
module tb_uart_rx_stream;

  localparam int CPB   = 16;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       uart_rx;
  logic       sm_tvalid;
  logic [7:0] sm_tdata;
  logic       sm_tready;
  logic [2:0] rx_count;
  logic       irq;
  logic       frame_err;
  logic       overrun;
  logic       err_clr;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int stop_cyc = 0;
  int last_beat_cyc = 0;
  int tv_cycles = 0;
  int irq_cycles = 0;
  logic [7:0] exp_q[$];

  uart_rx_stream #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .axis_clk  (clk),
    .axis_rst_n(rst_n),
    .uart_rx   (uart_rx),
    .sm_tvalid (sm_tvalid),
    .sm_tdata  (sm_tdata),
    .sm_tready (sm_tready),
    .rx_count  (rx_count),
    .irq       (irq),
    .frame_err (frame_err),
    .overrun   (overrun),
    .err_clr   (err_clr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // Handshake monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (sm_tvalid) tv_cycles++;
    if (irq) irq_cycles++;
    if (sm_tvalid && sm_tready) begin
      last_beat_cyc = cyc;
      if (exp_q.size() == 0) begin
        check_val("unexpected_beat_qsize", 32'(exp_q.size()), 32'd1);
      end else begin
        check_val("beat_tdata", {24'd0, sm_tdata}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  // All stimulus tasks start and end at posedge + #1.
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    uart_rx = 1'b0;
    idle(CPB);
    for (int i = 0; i < 8; i++) begin
      uart_rx = d[i];
      idle(CPB);
    end
    uart_rx  = stop_bit;
    stop_cyc = cyc;
    idle(CPB);
  endtask

  task automatic pulse_err_clr();
    err_clr = 1'b1;
    idle(1);
    err_clr = 1'b0;
    idle(1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d99;
    logic [7:0] bytes5 [5];
    int tv0;
    int irq0;

    rst_n     = 1'b0;
    uart_rx   = 1'b1;
    sm_tready = 1'b0;
    err_clr   = 1'b0;

    // Reset state
    idle(3);
    check_val("rst_tvalid", 32'(sm_tvalid), 0);
    check_val("rst_tdata", 32'(sm_tdata), 0);
    check_val("rst_count", 32'(rx_count), 0);
    check_val("rst_irq", 32'(irq), 0);
    check_val("rst_frame_err", 32'(frame_err), 0);
    check_val("rst_overrun", 32'(overrun), 0);
    rst_n = 1'b1;
    idle(10);
    check_val("post_rst_irq", 32'(irq), 0);

    // Single byte with ready high
    sm_tready = 1'b1;
    tv0  = tv_cycles;
    irq0 = irq_cycles;
    exp_q.push_back(8'h3D);
    send_frame(8'h3D, 1'b1);
    idle(4);
    check_val("t1_latency", 32'(last_beat_cyc - stop_cyc), 32'd12);
    check_val("t1_tvalid_cycles", 32'(tv_cycles - tv0), 32'd1);
    check_val("t1_irq_cycles", 32'(irq_cycles - irq0), 32'd1);
    check_val("t1_frame_err", 32'(frame_err), 0);
    check_val("t1_overrun", 32'(overrun), 0);
    check_val("t1_q_empty", 32'(exp_q.size()), 0);

    // Overflow with ready low
    sm_tready = 1'b0;
    bytes5[0] = 8'h0F; bytes5[1] = 8'hA5; bytes5[2] = 8'h5A;
    bytes5[3] = 8'hFF; bytes5[4] = 8'h81;
    for (int i = 0; i < 5; i++) begin
      if (i < DEPTH) exp_q.push_back(bytes5[i]);
      send_frame(bytes5[i], 1'b1);
      idle(3);
    end
    check_val("t2_count_full", 32'(rx_count), 32'd4);
    check_val("t2_overrun", 32'(overrun), 1);
    check_val("t2_tdata_held", 32'(sm_tdata), 32'h0F);
    sm_tready = 1'b1;
    idle(10);
    check_val("t2_count_drained", 32'(rx_count), 0);
    check_val("t2_irq_sticky", 32'(irq), 1);
    check_val("t2_q_empty", 32'(exp_q.size()), 0);
    pulse_err_clr();
    check_val("t2_overrun_clr", 32'(overrun), 0);
    check_val("t2_irq_clr", 32'(irq), 0);

    // Framing error followed by a break, then a good byte
    send_frame(8'h55, 1'b0);
    idle(20);
    uart_rx = 1'b1;
    idle(10);
    check_val("t3_frame_err", 32'(frame_err), 1);
    check_val("t3_count", 32'(rx_count), 0);
    check_val("t3_irq", 32'(irq), 1);
    pulse_err_clr();
    check_val("t3_frame_err_clr", 32'(frame_err), 0);
    exp_q.push_back(8'hC3);
    send_frame(8'hC3, 1'b1);
    idle(4);
    check_val("t3_q_empty", 32'(exp_q.size()), 0);
    check_val("t3_no_new_err", 32'(frame_err), 0);

    // Short low glitch
    uart_rx = 1'b0;
    idle(4);
    uart_rx = 1'b1;
    idle(40);
    check_val("t4_count", 32'(rx_count), 0);
    check_val("t4_frame_err", 32'(frame_err), 0);
    check_val("t4_overrun", 32'(overrun), 0);
    // The receiver must be idle again: a real frame decodes normally.
    exp_q.push_back(8'h6E);
    send_frame(8'h6E, 1'b1);
    idle(4);
    check_val("t4_q_empty", 32'(exp_q.size()), 0);

    // Reset during data bit 3 of 0x99, with a stale byte in the FIFO
    sm_tready = 1'b0;
    send_frame(8'h11, 1'b1);
    idle(4);
    check_val("t5_pre_count", 32'(rx_count), 1);
    d99 = 8'h99;
    uart_rx = 1'b0;
    idle(CPB);
    for (int i = 0; i < 3; i++) begin
      uart_rx = d99[i];
      idle(CPB);
    end
    uart_rx = d99[3];
    idle(CPB / 2);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("t5_async_count", 32'(rx_count), 0);
    check_val("t5_async_tvalid", 32'(sm_tvalid), 0);
    check_val("t5_async_tdata", 32'(sm_tdata), 0);
    uart_rx = 1'b1;
    idle(4);
    rst_n = 1'b1;
    idle(20);
    check_val("t5_post_count", 32'(rx_count), 0);
    check_val("t5_post_irq", 32'(irq), 0);
    sm_tready = 1'b1;
    exp_q.push_back(8'h42);
    send_frame(8'h42, 1'b1);
    idle(4);
    check_val("t5_q_empty", 32'(exp_q.size()), 0);

    // Full FIFO, pop coincides with the 5th push
    sm_tready = 1'b0;
    bytes5[0] = 8'h10; bytes5[1] = 8'h20; bytes5[2] = 8'h30;
    bytes5[3] = 8'h40; bytes5[4] = 8'hE7;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(bytes5[i]);
      send_frame(bytes5[i], 1'b1);
      idle(3);
    end
    check_val("t6_count_full", 32'(rx_count), 32'd4);
    exp_q.push_back(bytes5[4]);
    fork
      send_frame(bytes5[4], 1'b1);
      begin
        idle(9 * CPB + CPB - 5);
        sm_tready = 1'b1;
        idle(1);
        sm_tready = 1'b0;
      end
    join
    check_val("t6_count_kept", 32'(rx_count), 32'd4);
    check_val("t6_overrun", 32'(overrun), 0);
    sm_tready = 1'b1;
    idle(10);
    check_val("t6_count_drained", 32'(rx_count), 0);
    check_val("t6_q_empty", 32'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
